// File: rtl/fht_but_wb_if.sv
// Result-pair input, RAM write port and stage handshake of the FHT butterfly write-back unit.
interface fht_but_wb_if #(
  parameter int D_BIT = 18,
  parameter int A_BIT = 10
);
  logic             iVALID;
  logic [D_BIT-1:0] iY_0;
  logic [D_BIT-1:0] iY_1;
  logic [A_BIT-1:0] iADDR_0;
  logic [A_BIT-1:0] iADDR_1;
  logic             oREADY;
  logic             iWR_WAIT;
  logic             oWR_EN;
  logic [A_BIT-1:0] oWR_ADDR;
  logic [D_BIT-1:0] oWR_DATA;
  logic             iSTAGE_END;
  logic             oDONE;
  logic             oERR;

  modport slave (
    input  iVALID, iY_0, iY_1, iADDR_0, iADDR_1, iWR_WAIT, iSTAGE_END,
    output oREADY, oWR_EN, oWR_ADDR, oWR_DATA, oDONE, oERR
  );

  modport master (
    output iVALID, iY_0, iY_1, iADDR_0, iADDR_1, iWR_WAIT, iSTAGE_END,
    input  oREADY, oWR_EN, oWR_ADDR, oWR_DATA, oDONE, oERR
  );
endinterface

// File: rtl/fht_but_wb.sv
// FHT write-back: queues result pairs, writes Y0 then Y1 (first write one cycle after accept),
// oREADY low when the pair FIFO is full, iWR_WAIT holds the current write; oDONE ends a stage.
module fht_but_wb #(
  parameter int D_BIT = 18,
  parameter int A_BIT = 10,
  parameter int DEPTH = 4
) (
  input  logic        iCLK,
  input  logic        iRESET,
  fht_but_wb_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [D_BIT-1:0] y0;
    logic [D_BIT-1:0] y1;
    logic [A_BIT-1:0] a0;
    logic [A_BIT-1:0] a1;
  } pair_t;

  typedef enum logic [1:0] {IDLE, W0, W1} state_t;

  pair_t            mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nx;
  state_t           state;
  state_t           state_nx;
  logic             wr_en_nx;
  logic [A_BIT-1:0] wr_addr_nx;
  logic [D_BIT-1:0] wr_data_nx;
  logic             push;
  logic             pop;
  logic             pend;
  logic             pend_nx;
  logic             done_nx;
  pair_t            in_pair;
  pair_t            head;
  pair_t            after;
  pair_t            src;

  assign bus.oREADY = (count < CW'(DEPTH));
  assign push       = bus.iVALID & bus.oREADY;
  assign in_pair    = '{y0: bus.iY_0, y1: bus.iY_1, a0: bus.iADDR_0, a1: bus.iADDR_1};
  assign head       = mem[rd_ptr];
  assign after      = mem[rd_ptr + PW'(1)];

  // Incoming pair bypasses the FIFO when it is the next to be written, so no bubble appears.
  always_comb begin
    state_nx   = state;
    wr_en_nx   = 1'b0;
    wr_addr_nx = '0;
    wr_data_nx = '0;
    pop        = 1'b0;
    src        = in_pair;
    case (state)
      IDLE: begin
        src = (count != '0) ? head : in_pair;
        if ((count != '0) || push) begin
          state_nx   = W0;
          wr_en_nx   = 1'b1;
          wr_addr_nx = src.a0;
          wr_data_nx = src.y0;
        end
      end
      W0: begin
        wr_en_nx = 1'b1;
        if (bus.iWR_WAIT) begin
          wr_addr_nx = head.a0;
          wr_data_nx = head.y0;
        end else begin
          state_nx   = W1;
          wr_addr_nx = head.a1;
          wr_data_nx = head.y1;
        end
      end
      W1: begin
        if (bus.iWR_WAIT) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = head.a1;
          wr_data_nx = head.y1;
        end else begin
          pop = 1'b1;
          src = (count > CW'(1)) ? after : in_pair;
          if ((count > CW'(1)) || push) begin
            state_nx   = W0;
            wr_en_nx   = 1'b1;
            wr_addr_nx = src.a0;
            wr_data_nx = src.y0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    count_nx = count + CW'(push) - CW'(pop);
    done_nx  = (pend | bus.iSTAGE_END) & (state_nx == IDLE) & (count_nx == '0);
    pend_nx  = done_nx ? 1'b0 : (pend | bus.iSTAGE_END);
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_pair;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      pend         <= 1'b0;
      bus.oWR_EN   <= 1'b0;
      bus.oWR_ADDR <= '0;
      bus.oWR_DATA <= '0;
      bus.oDONE    <= 1'b0;
      bus.oERR     <= 1'b0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      pend         <= pend_nx;
      bus.oWR_EN   <= wr_en_nx;
      bus.oWR_ADDR <= wr_addr_nx;
      bus.oWR_DATA <= wr_data_nx;
      bus.oDONE    <= done_nx;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && (bus.iADDR_0 == bus.iADDR_1)) bus.oERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fht_but_wb.sv
// Randomised and directed bench for fht_but_wb against a queue-of-writes reference model.
module tb_fht_but_wb;
  localparam int D_BIT = 18;
  localparam int A_BIT = 10;
  localparam int DEPTH = 4;

  logic iCLK = 1'b0;
  logic iRESET = 1'b1;

  fht_but_wb_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

  fht_but_wb #(.D_BIT(D_BIT), .A_BIT(A_BIT), .DEPTH(DEPTH)) dut (
    .iCLK  (iCLK),
    .iRESET(iRESET),
    .bus   (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [A_BIT-1:0] a;
    logic [D_BIT-1:0] d;
  } wr_t;

  // Model: every accepted pair becomes two pending RAM writes; a pair occupies the FIFO until its Y1 lands.
  wr_t wq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  m_err, m_pend, m_done, m_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int outstanding();
    return (wq.size() + 1) / 2;
  endfunction

  task automatic check_outputs();
    chk("ready", 32'(bus.oREADY), 32'(outstanding() < DEPTH));
    chk("wr_en", 32'(bus.oWR_EN), 32'(wq.size() > 0));
    if (wq.size() > 0 && bus.oWR_EN) begin
      chk("wr_addr", 32'(bus.oWR_ADDR), 32'(wq[0].a));
      chk("wr_data", 32'(bus.oWR_DATA), 32'(wq[0].d));
    end
    chk("done", 32'(bus.oDONE), 32'(m_done));
    chk("err", 32'(bus.oERR), 32'(m_err));
  endtask

  task automatic step();
    bit acc, comp, se;
    acc = bus.iVALID && (outstanding() < DEPTH);
    @(posedge iCLK);
    comp = (wq.size() > 0) && !bus.iWR_WAIT;
    se   = bus.iSTAGE_END;
    if (comp) void'(wq.pop_front());
    if (acc) begin
      wq.push_back('{bus.iADDR_0, bus.iY_0});
      wq.push_back('{bus.iADDR_1, bus.iY_1});
      if (bus.iADDR_0 == bus.iADDR_1) m_err = 1'b1;
    end
    m_acc  = acc;
    m_done = (m_pend || se) && (wq.size() == 0);
    m_pend = m_done ? 1'b0 : (m_pend || se);
    @(negedge iCLK);
    check_outputs();
  endtask

  task automatic set_pair(input logic [A_BIT-1:0] a0, input logic [A_BIT-1:0] a1,
                          input logic [D_BIT-1:0] y0, input logic [D_BIT-1:0] y1);
    bus.iVALID  = 1'b1;
    bus.iADDR_0 = a0;
    bus.iADDR_1 = a1;
    bus.iY_0    = y0;
    bus.iY_1    = y1;
  endtask

  task automatic drain(input int n);
    bus.iVALID     = 1'b0;
    bus.iSTAGE_END = 1'b0;
    bus.iWR_WAIT   = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    bus.iVALID     = 1'b0;
    bus.iSTAGE_END = 1'b0;
    bus.iWR_WAIT   = 1'b0;
    #2;
    iRESET = 1'b1;
    #1;
    chk("rst_wr_en", 32'(bus.oWR_EN), 32'd0);
    chk("rst_wr_addr", 32'(bus.oWR_ADDR), 32'd0);
    chk("rst_wr_data", 32'(bus.oWR_DATA), 32'd0);
    chk("rst_done", 32'(bus.oDONE), 32'd0);
    chk("rst_err", 32'(bus.oERR), 32'd0);
    wq.delete();
    m_err  = 1'b0;
    m_pend = 1'b0;
    m_done = 1'b0;
    m_acc  = 1'b0;
    @(negedge iCLK);
    iRESET = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.oREADY), 32'd1);
  endtask

  initial begin
    bus.iVALID     = 1'b0;
    bus.iY_0       = '0;
    bus.iY_1       = '0;
    bus.iADDR_0    = '0;
    bus.iADDR_1    = '0;
    bus.iWR_WAIT   = 1'b0;
    bus.iSTAGE_END = 1'b0;
    do_reset();

    // Single pair: Y0 write in k+1, Y1 in k+2, idle in k+3.
    set_pair(10'd5, 10'd9, 18'h00100, 18'h3FF00);
    step();
    drain(4);

    // Fill and backpressure: source holds a pair until it is taken.
    begin
      int k = 0;
      for (int c = 0; c < 10; c++) begin
        set_pair(10'(20 + 2 * k), 10'(21 + 2 * k), 18'(16'hA000 + k), 18'(16'hB000 + k));
        step();
        if (m_acc) k++;
      end
    end
    drain(14);

    // Stall three cycles while the Y0 write is presented.
    set_pair(10'd100, 10'd101, 18'h12345, 18'h2ABCD);
    step();
    bus.iVALID   = 1'b0;
    bus.iWR_WAIT = 1'b1;
    repeat (3) step();
    drain(4);

    // End of stage after three pairs, then on an idle block.
    for (int p = 0; p < 3; p++) begin
      set_pair(10'(200 + p), 10'(300 + p), 18'(p + 1), 18'(18'h20000 | p));
      step();
    end
    bus.iVALID     = 1'b0;
    bus.iSTAGE_END = 1'b1;
    step();
    bus.iSTAGE_END = 1'b1;
    step();
    drain(8);
    bus.iSTAGE_END = 1'b1;
    step();
    drain(3);

    // Address collision, then a clean pair that must not clear the flag.
    set_pair(10'd7, 10'd7, 18'h01111, 18'h02222);
    step();
    set_pair(10'd8, 10'd9, 18'h03333, 18'h04444);
    step();
    drain(6);

    // Reset while in W1 with pairs still queued.
    bus.iWR_WAIT = 1'b1;
    for (int p = 0; p < 3; p++) begin
      set_pair(10'(400 + p), 10'(500 + p), 18'(18'h10000 + p), 18'(18'h11000 + p));
      step();
    end
    bus.iVALID   = 1'b0;
    bus.iWR_WAIT = 1'b0;
    step();
    bus.iWR_WAIT = 1'b1;
    step();
    do_reset();
    set_pair(10'd600, 10'd601, 18'h0F0F0, 18'h30303);
    step();
    drain(4);

    // Randomised traffic with stalls, collisions and stage ends.
    for (int c = 0; c < 800; c++) begin
      if (!bus.iVALID || m_acc) begin
        logic [A_BIT-1:0] a0;
        a0 = A_BIT'($urandom);
        bus.iADDR_0 = a0;
        bus.iADDR_1 = ($urandom_range(0, 7) == 0) ? a0 : A_BIT'($urandom);
        bus.iY_0    = D_BIT'($urandom);
        bus.iY_1    = D_BIT'($urandom);
      end
      bus.iVALID     = ($urandom_range(0, 3) != 0) || (bus.iVALID && !m_acc);
      bus.iWR_WAIT   = ($urandom_range(0, 3) == 0);
      bus.iSTAGE_END = ($urandom_range(0, 15) == 0);
      step();
    end
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
